osu_sc_elastic_buf: RTL and testbench

//   Parametrised, clocked successor to the single-bit combinational buffer cell.

---
 rtl/osu_sc_elbuf_pkg.sv | 16 +
 rtl/osu_sc_elbuf_ptr.sv | 25 ++
 rtl/osu_sc_elastic_buf.sv | 74 +++++++
 tb/tb_osu_sc_elastic_buf.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/osu_sc_elbuf_pkg.sv
// osu_sc_elbuf_pkg: sizing and pointer helpers shared by the elastic buffer and its pointer cells.
package osu_sc_elbuf_pkg;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer width rule: enough bits to index DEPTH entries, never zero bits.
    localparam int ELBUF_DEPTH_DEF = 2;
    localparam int ELBUF_PTR_W_DEF = clog2_safe(ELBUF_DEPTH_DEF);

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/osu_sc_elbuf_ptr.sv
// osu_sc_elbuf_ptr: wrapping pointer register, wraps DEPTH-1 -> 0 for any DEPTH.
module osu_sc_elbuf_ptr
    import osu_sc_elbuf_pkg::*;
#(
    parameter int DEPTH = ELBUF_DEPTH_DEF,
    parameter int PTR_W = clog2_safe(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb ptr_d = inc_i ? PTR_W'(ptr_inc(int'(ptr_q), DEPTH)) : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/osu_sc_elastic_buf.sv
// osu_sc_elastic_buf: DEPTH-entry valid/ready elastic buffer, full throughput, registered handshakes.
// Define OSU_SC_ELBUF_LVL_EN to expose the occupancy count on port LVL.
module osu_sc_elastic_buf
    import osu_sc_elbuf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = ELBUF_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic             A_VLD,
    output logic             A_RDY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VLD,
    input  logic             Y_RDY
`ifdef OSU_SC_ELBUF_LVL_EN
   ,output logic [clog2_safe(DEPTH+1)-1:0] LVL
`endif
);

    localparam int PTR_W = clog2_safe(DEPTH);
    localparam int CNT_W = clog2_safe(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy_q, vld_q, push, pop;

    assign push = A_VLD & rdy_q;
    assign pop  = vld_q & Y_RDY;

    always_comb count_d = (push == pop) ? count_q : (push ? count_q + 1'b1 : count_q - 1'b1);

    // Ready and valid are derived from next-state count so both stay pure registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            count_q <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            rdy_q   <= count_d < CNT_W'(DEPTH);
            vld_q   <= count_d != '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr] <= A;
    end

    osu_sc_elbuf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk_i (CLK),
        .rst_ni(RN),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    osu_sc_elbuf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk_i (CLK),
        .rst_ni(RN),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    assign A_RDY = rdy_q;
    assign Y_VLD = vld_q;
    assign Y     = vld_q ? mem_q[rd_ptr] : '0;

`ifdef OSU_SC_ELBUF_LVL_EN
    assign LVL = count_q;
`endif

endmodule

// File: tb/tb_osu_sc_elastic_buf.sv
// tb_osu_sc_elastic_buf: scoreboard bench driving DEPTH=2, 3 and 5 instances off one clock and reset.
module tb_osu_sc_elastic_buf;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic [7:0] a     [3];
    logic       a_vld [3];
    logic       a_rdy [3];
    logic [7:0] y     [3];
    logic       y_vld [3];
    logic       y_rdy [3];
    int         dep   [3] = '{2, 3, 5};
    logic [7:0] sb    [3][$];
    logic       rdy_m [3];
    logic       push_m[3];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 CLK = ~CLK;

`ifdef OSU_SC_ELBUF_LVL_EN
    logic [1:0] lvl0, lvl1;
    logic [2:0] lvl2;
    function automatic int lvl_of(input int k);
        return (k == 0) ? int'(lvl0) : (k == 1) ? int'(lvl1) : int'(lvl2);
    endfunction
`endif

    osu_sc_elastic_buf #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .CLK(CLK), .RN(RN), .A(a[0]), .A_VLD(a_vld[0]), .A_RDY(a_rdy[0]),
        .Y(y[0]), .Y_VLD(y_vld[0]), .Y_RDY(y_rdy[0])
`ifdef OSU_SC_ELBUF_LVL_EN
       ,.LVL(lvl0)
`endif
    );

    osu_sc_elastic_buf #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .CLK(CLK), .RN(RN), .A(a[1]), .A_VLD(a_vld[1]), .A_RDY(a_rdy[1]),
        .Y(y[1]), .Y_VLD(y_vld[1]), .Y_RDY(y_rdy[1])
`ifdef OSU_SC_ELBUF_LVL_EN
       ,.LVL(lvl1)
`endif
    );

    osu_sc_elastic_buf #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .CLK(CLK), .RN(RN), .A(a[2]), .A_VLD(a_vld[2]), .A_RDY(a_rdy[2]),
        .Y(y[2]), .Y_VLD(y_vld[2]), .Y_RDY(y_rdy[2])
`ifdef OSU_SC_ELBUF_LVL_EN
       ,.LVL(lvl2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            a_vld[k] = 1'b0;
            y_rdy[k] = 1'b0;
            a[k]     = 8'h00;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), 32'(y_vld[k]), 32'd0);
            chk($sformatf("%s_y%0d", tag, k), 32'(y[k]), 32'd0);
            chk($sformatf("%s_rdy%0d", tag, k), 32'(a_rdy[k]), 32'd0);
        end
    endtask

    // Checks every instance mid-cycle, then advances the model across one rising edge.
    task automatic step();
        logic vld_e;
        logic pop_e;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            vld_e = sb[k].size() != 0;
            chk($sformatf("a_rdy%0d", k), 32'(a_rdy[k]), 32'(rdy_m[k]));
            chk($sformatf("y_vld%0d", k), 32'(y_vld[k]), 32'(vld_e));
`ifdef OSU_SC_ELBUF_LVL_EN
            chk($sformatf("lvl%0d", k), 32'(lvl_of(k)), 32'(sb[k].size()));
`endif
            if (!vld_e) chk($sformatf("y_idle%0d", k), 32'(y[k]), 32'd0);
            push_m[k] = a_vld[k] & rdy_m[k];
            pop_e     = vld_e & y_rdy[k];
            if (pop_e) chk($sformatf("y_data%0d", k), 32'(y[k]), 32'(sb[k].pop_front()));
        end
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (push_m[k]) sb[k].push_back(a[k]);
            rdy_m[k] = sb[k].size() < dep[k];
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RN = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("rel_rdy%0d", k), 32'(a_rdy[k]), 32'd0);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy_m[k] = 1'b1;
            chk($sformatf("first_edge_rdy%0d", k), 32'(a_rdy[k]), 32'd1);
        end
    endtask

    task automatic drain(input int k, input int cycles);
        a_vld[k] = 1'b0;
        y_rdy[k] = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        chk($sformatf("drained%0d", k), 32'(sb[k].size()), 32'd0);
        y_rdy[k] = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        idle_all();
        for (int k = 0; k < 3; k++) begin
            rdy_m[k] = 1'b0;
            a_vld[k] = 1'b1;
            a[k]     = 8'hEE;
        end
        #1;
        chk_reset_outputs("rst0");
        repeat (2) begin
            @(negedge CLK);
            chk_reset_outputs("rst_hold");
        end
        release_reset();
        idle_all();

        y_rdy[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_vld[0] = 1'b1;
            a[0]     = 8'(i);
            step();
            chk("d2_stream_accept", 32'(push_m[0]), 32'd1);
        end
        drain(0, 3);

        for (int i = 0; i < 3; i++) begin
            a_vld[1] = 1'b1;
            a[1]     = 8'hA1 + 8'(i);
            step();
        end
        a[1] = 8'hA4;
        repeat (2) begin
            step();
            chk("d3_full_reject", 32'(push_m[1]), 32'd0);
        end
        drain(1, 5);

        for (int i = 0; i < 3; i++) begin
            a_vld[1] = 1'b1;
            a[1]     = 8'hB1 + 8'(i);
            step();
        end
        a[1]     = 8'hB4;
        y_rdy[1] = 1'b1;
        step();
        chk("d3_full_pop_nopush", 32'(push_m[1]), 32'd0);
        step();
        chk("d3_after_pop_push", 32'(push_m[1]), 32'd1);
        drain(1, 6);

        sent = 0;
        cyc  = 0;
        while (cyc < 300 && (sent < 12 || sb[2].size() != 0)) begin
            a_vld[2] = sent < 12;
            a[2]     = 8'hC0 + 8'(sent);
            y_rdy[2] = (sent >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            if (push_m[2]) sent++;
            cyc++;
        end
        chk("d5_wrap_done", 32'(sent == 12 && sb[2].size() == 0), 32'd1);
        idle_all();

        for (int i = 0; i < 2; i++) begin
            a_vld[0] = 1'b1;
            a[0]     = 8'hD1 + 8'(i);
            step();
        end
        a_vld[0] = 1'b0;
        chk("mid_pre_vld", 32'(y_vld[0]), 32'd1);
        #2;
        RN = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            rdy_m[k] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        release_reset();
        a_vld[0] = 1'b1;
        a[0]     = 8'h5A;
        step();
        a_vld[0] = 1'b0;
        chk("mid_first_word_head", 32'(y[0]), 32'h5A);
        drain(0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
